logic_capture_buffer: RTL and testbench

Capture stage directly upstream of the logic display pixel generator. Synchronises the four probe inputs, samples them at a programmable rate, waits for a trigger edge on a selected channel, and then records one screen's worth of samples into a 4-bit-wide buffer. Once the buffer is full it freezes it and serves one 4-bit sample per display column, addressed by the same `x` the pixel generator receives.

---
 rtl/logic_analyzer_pkg.sv | 19 +
 rtl/capture_ram.sv | 36 +++
 rtl/logic_capture_buffer.sv | 164 ++++++++++++++++
 tb/tb_logic_capture_buffer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_analyzer_pkg.sv
// Shared constants and FSM state type for the logic analyzer capture and display path.
package logic_analyzer_pkg;

    localparam int unsigned DISPLAY_W  = 96;
    localparam int unsigned DISPLAY_H  = 64;
    localparam int unsigned LABEL_W    = 8;
    localparam int unsigned SAMPLES    = DISPLAY_W - LABEL_W;
    localparam int unsigned PRESCALE_W = 16;
    localparam int unsigned CH_W       = 4;
    localparam int unsigned ADDR_W     = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } cap_state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one synchronous write port, one synchronous masked read port.
module capture_ram #(
    parameter int unsigned DEPTH  = 88,
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Masked reads return zero so the display never sees stale contents.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end else begin
            o_rdata <= '0;
        end
    end

endmodule

// File: rtl/logic_capture_buffer.sv
// Probe synchroniser, sample-rate divider, edge/force trigger and one-screen capture buffer
// read out by display column.
module logic_capture_buffer
    import logic_analyzer_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [CH_W-1:0]       i_probe_in,
    input  logic                  i_arm,
    input  logic                  i_force_trig,
    input  logic [1:0]            i_trig_ch,
    input  logic                  i_trig_rise,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic [ADDR_W-1:0]     i_x,
    output logic [CH_W-1:0]       o_sample,
    output logic                  o_armed,
    output logic                  o_done
);

    logic [CH_W-1:0]       r_sync1;
    logic [CH_W-1:0]       r_sync2;
    logic [CH_W-1:0]       r_prev;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic                  r_prev_valid;
    logic                  r_force;
    logic                  r_valid;
    logic [ADDR_W-1:0]     r_waddr;
    cap_state_t            r_state;
    cap_state_t            w_state_nxt;

    logic                  w_tick;
    logic                  w_edge;
    logic                  w_force_seen;
    logic                  w_trig;
    logic                  w_we;
    logic                  w_re;
    logic                  w_in_range;
    logic [ADDR_W-1:0]     w_ram_waddr;
    logic [ADDR_W-1:0]     w_raddr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_probe_in;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running divider: tick whenever the down-counter reaches zero.
    assign w_tick = (r_pcnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst || w_tick) begin
            r_pcnt <= i_prescale;
        end else begin
            r_pcnt <= r_pcnt - PRESCALE_W'(1);
        end
    end

    assign w_edge = r_prev_valid
                  && (r_sync2[i_trig_ch] != r_prev[i_trig_ch])
                  && (r_sync2[i_trig_ch] == i_trig_rise);
    assign w_force_seen = r_force | i_force_trig;
    assign w_trig       = w_tick && (w_edge || w_force_seen);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_ram_waddr = r_waddr;
        case (r_state)
            ST_IDLE: begin
                if (i_arm) w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (w_trig) begin
                    w_we        = 1'b1;
                    w_ram_waddr = '0;
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (w_tick) begin
                    w_we = 1'b1;
                    if (r_waddr == ADDR_W'(SAMPLES - 1)) w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_arm) w_state_nxt = ST_ARMED;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Trigger history, force latch, write pointer and completed-capture flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_force      <= 1'b0;
            r_waddr      <= '0;
            r_valid      <= 1'b0;
        end else begin
            if (r_state != ST_ARMED && w_state_nxt == ST_ARMED) begin
                r_prev_valid <= 1'b0;
                r_force      <= 1'b0;
            end else if (r_state == ST_ARMED) begin
                r_force <= (w_state_nxt == ST_ARMED) && w_force_seen;
                if (w_tick) begin
                    r_prev       <= r_sync2;
                    r_prev_valid <= 1'b1;
                end
            end
            if (r_state == ST_ARMED && w_trig) begin
                r_waddr <= ADDR_W'(1);
            end else if (r_state == ST_CAPTURE && w_tick && r_waddr != ADDR_W'(SAMPLES - 1)) begin
                r_waddr <= r_waddr + ADDR_W'(1);
            end
            if (r_state == ST_CAPTURE && w_state_nxt == ST_DONE) begin
                r_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_armed <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_armed <= (w_state_nxt == ST_ARMED) || (w_state_nxt == ST_CAPTURE);
            o_done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Reads only while frozen in DONE and staying there, so no read ever meets the final write.
    assign w_in_range = (i_x >= ADDR_W'(LABEL_W)) && (i_x < ADDR_W'(LABEL_W + SAMPLES));
    assign w_raddr    = i_x - ADDR_W'(LABEL_W);
    assign w_re       = r_valid && (r_state == ST_DONE) && (w_state_nxt == ST_DONE) && w_in_range;

    capture_ram #(
        .DEPTH  (SAMPLES),
        .WIDTH  (CH_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (r_sync2),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (o_sample)
    );

endmodule

// File: tb/tb_logic_capture_buffer.sv
// Randomised bench for logic_capture_buffer against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_logic_capture_buffer;

    localparam int NS = 88;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  probe_in;
    logic        arm;
    logic        force_trig;
    logic [1:0]  trig_ch;
    logic        trig_rise;
    logic [15:0] prescale;
    logic [6:0]  x;
    logic [3:0]  sample;
    logic        armed;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    // Probe stimulus: 0 hold, 1 counter, 2 random, 3 CH3 high for 20 clocks then low
    int         pmode = 0;
    logic [3:0] pcount = '0;
    int         fall_cnt = 0;

    // Model state: IDLE=0 ARMED=1 CAPTURE=2 DONE=3
    logic [3:0] m_s1, m_s, m_prev;
    logic [3:0] m_buf [NS];
    int         m_cnt, m_mode, m_waddr;
    bit         m_pv, m_force, m_valid;
    logic [3:0] e_sample;
    bit         e_armed, e_done;

    logic_capture_buffer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_probe_in   (probe_in),
        .i_arm        (arm),
        .i_force_trig (force_trig),
        .i_trig_ch    (trig_ch),
        .i_trig_rise  (trig_rise),
        .i_prescale   (prescale),
        .i_x          (x),
        .o_sample     (sample),
        .o_armed      (armed),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Apply the inputs present just before a clock edge to the model.
    task automatic model_edge();
        bit         tick, edge_ok, fseen;
        int         nmode, xi;
        logic [3:0] s;
        if (rst) begin
            m_s1 = '0; m_s = '0; m_prev = '0;
            m_cnt = int'(prescale); m_mode = 0; m_waddr = 0;
            m_pv = 0; m_force = 0; m_valid = 0;
            e_sample = '0; e_armed = 0; e_done = 0;
            return;
        end
        s     = m_s;
        tick  = (m_cnt == 0);
        nmode = m_mode;
        case (m_mode)
            0: if (arm) nmode = 1;
            1: begin
                fseen   = m_force || force_trig;
                edge_ok = m_pv && (s[trig_ch] != m_prev[trig_ch]) && (s[trig_ch] == trig_rise);
                if (tick && (edge_ok || fseen)) begin
                    m_buf[0] = s;
                    m_waddr  = 1;
                    nmode    = 2;
                end
                if (tick) begin
                    m_prev = s;
                    m_pv   = 1;
                end
                m_force = fseen;
            end
            2: if (tick) begin
                m_buf[m_waddr] = s;
                if (m_waddr == NS - 1) nmode = 3;
                m_waddr++;
            end
            default: if (arm) nmode = 1;
        endcase
        if (nmode == 1 && m_mode != 1) begin
            m_pv    = 0;
            m_force = 0;
        end
        xi = int'(x);
        if (m_mode == 3 && nmode == 3 && m_valid && xi >= 8 && xi < 8 + NS)
            e_sample = m_buf[xi - 8];
        else
            e_sample = '0;
        if (m_mode == 2 && nmode == 3) m_valid = 1;
        m_cnt   = tick ? int'(prescale) : m_cnt - 1;
        m_s     = m_s1;
        m_s1    = probe_in;
        m_mode  = nmode;
        e_armed = (nmode == 1 || nmode == 2);
        e_done  = (nmode == 3);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("sample", 32'(sample), 32'(e_sample));
        check("armed", 32'(armed), 32'(e_armed));
        check("done", 32'(done), 32'(e_done));
        case (pmode)
            1: begin pcount = pcount + 4'd1; probe_in = pcount; end
            2: probe_in = 4'($urandom);
            3: begin fall_cnt++; probe_in = {1'(fall_cnt <= 20), 3'($urandom)}; end
            default: ;
        endcase
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic sweep();
        for (int i = 0; i < 128; i++) begin
            x = 7'(i);
            cyc();
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    task automatic pulse_force();
        force_trig = 1'b1;
        cyc();
        force_trig = 1'b0;
    endtask

    task automatic run_done(input string tag, input int maxc);
        int i = 0;
        while (!done && i < maxc) begin
            cyc();
            i++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; probe_in = '0; arm = 1'b0; force_trig = 1'b0;
        trig_ch = 2'd1; trig_rise = 1'b1; prescale = 16'd0; x = '0;

        // Reset, then every column reads zero
        cycles(2);
        rst = 1'b0;
        sweep();

        // Rising edge on CH1 with counter probes, one sample per clock
        cycles(3);
        pulse_arm();
        pcount = '0; pmode = 1;
        run_done("rise_done", 300);
        pmode = 0;
        x = 7'd8;
        cyc();
        check("rise_first", 32'(sample), 32'h2);
        sweep();

        // Falling edge on CH3, prescale 3
        prescale = 16'd3; trig_ch = 2'd3; trig_rise = 1'b0;
        probe_in = 4'h8;
        cycles(6);
        pulse_arm();
        fall_cnt = 0; pmode = 3;
        run_done("fall_done", 700);
        pmode = 0;
        x = 7'd8;
        cyc();
        check("fall_a0_ch3", 32'(sample[3]), 32'd0);
        sweep();

        // Force trigger with static probes
        prescale = 16'd1;
        probe_in = 4'hA;
        cycles(4);
        pulse_arm();
        cycles(5);
        pulse_force();
        run_done("force_done", 400);
        sweep();
        x = 7'd50; cyc();
        check("force_val", 32'(sample), 32'hA);
        x = 7'd3; cyc();
        check("force_label", 32'(sample), 32'h0);

        // Arm ignored during CAPTURE, then re-arm from DONE
        trig_ch = 2'd0; trig_rise = 1'b1; pmode = 2;
        pulse_arm();
        for (int i = 0; i < 200 && m_mode != 2; i++) cyc();
        check("cap_reached", 32'(armed), 32'd1);
        cycles(20);
        pulse_arm();
        run_done("ignored_arm_done", 400);
        pmode = 0; probe_in = '0;
        sweep();
        pulse_arm();
        check("rearm_done_low", 32'(done), 32'd0);
        sweep();
        pulse_force();
        run_done("rearm_done", 400);
        sweep();

        // Reset in the middle of a capture, then a clean capture
        prescale = 16'd0; trig_ch = 2'd2; pmode = 2;
        pulse_arm();
        pulse_force();
        for (int i = 0; i < 200 && m_waddr != 40; i++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_mid_idle", 32'(armed), 32'd0);
        sweep();
        pulse_arm();
        pulse_force();
        run_done("post_rst_done", 400);
        sweep();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
